mem_access_ctrl: RTL

Sequencing controller for the SLC-3 memory path (MAR, MDR, SRAM).
- Takes a single-beat read or write request from the CPU control FSM.
- Strobes MAR and MDR loads, drives the SRAM control pins for a parameterised number of wait states, and returns a one-cycle completion pulse.
- Sits between the main control FSM and the MAR/MDR/SRAM interface; owns all SRAM timing so the CPU FSM only issues requests.

---
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// SLC-3 memory path sequencer: strobes MAR/MDR and times the SRAM control pins
// for single-beat reads and writes, ending each transaction with a one-cycle done pulse.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic rd_req,
    input  logic wr_req,
    output logic ready,
    output logic busy,
    output logic done,
    output logic ld_mar,
    output logic ld_mdr,
    output logic mio_en,
    output logic mem_drive,
    output logic CE_N,
    output logic OE_N,
    output logic WE_N
);

    typedef enum logic [2:0] {IDLE, LOAD_MAR, ACCESS, HOLD, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_wr, op_wr_nxt;
    logic             last;

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_wr <= op_wr_nxt;
        end
    end

    // Outputs depend only on state, cnt and op_wr, never on the request inputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_wr_nxt = op_wr;
        ready     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        ld_mar    = 1'b0;
        ld_mdr    = 1'b0;
        mio_en    = 1'b0;
        mem_drive = 1'b0;
        CE_N      = 1'b1;
        OE_N      = 1'b1;
        WE_N      = 1'b1;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (rd_req) begin
                    state_nxt = LOAD_MAR;
                    op_wr_nxt = 1'b0;
                end else if (wr_req) begin
                    state_nxt = LOAD_MAR;
                    op_wr_nxt = 1'b1;
                end
            end
            LOAD_MAR: begin
                ld_mar    = 1'b1;
                ld_mdr    = op_wr;
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                CE_N = 1'b0;
                if (op_wr) begin
                    WE_N      = 1'b0;
                    mem_drive = 1'b1;
                end else begin
                    OE_N   = 1'b0;
                    mio_en = 1'b1;
                    ld_mdr = last;
                end
                cnt_nxt = last ? '0 : cnt + 1'b1;
                if (last) state_nxt = op_wr ? HOLD : DONE;
            end
            HOLD: begin
                // Keep data on the pins one cycle past the WE_N rising edge.
                CE_N      = 1'b0;
                mem_drive = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    a_oe_we_excl:  assert property (@(posedge Clk) !(!OE_N && !WE_N));
    a_drive_oe:    assert property (@(posedge Clk) !(mem_drive && !OE_N));
    a_cnt_bound:   assert property (@(posedge Clk) cnt <= CNT_LAST);

endmodule
